onehot_grant_arbiter: RTL and testbench
=======================================

// Module: onehot_grant_arbiter
//
// PURPOSE
//   Round-robin arbiter that drives a registered, mutually exclusive (one-hot-or-zero)
//   grant vector to N requesters. It is the producer side of the one-hot rule that our
//   concurrent assertions check: at most one grant is ever high on any posedge clk.
//   A grant is held until the owner signals done, drops its request, or hits a hold
//   limit. Every grant change passes through a zero-grant gap cycle (break-before-make).
//
// PARAMETERS
//   N         4   number of requesters (>=2)
//   MAX_HOLD  8   maximum consecutive cycles one grant may stay high (>=1)
//
// PORTS
//   clk        input   1           clock, all state updates on posedge clk
//   rst_n      input   1           asynchronous active-low reset
//   req        input   N           request per requester, level-sensitive
//   done       input   N           owner-finished pulse; only done[owner] is honoured
//   gnt        output  N           registered grant, one-hot or all-zero
//   gnt_valid  output  1           registered, equals |gnt
//   gnt_id     output  $clog2(N)   registered index of the granted requester, 0 when idle
//   timeout    output  1           registered 1-cycle pulse when a grant is revoked by MAX_HOLD
//
// BEHAVIOUR
//   Reset (rst_n=0, async): gnt=0, gnt_valid=0, gnt_id=0, timeout=0, state=IDLE,
//     ptr=N-1 (so requester 0 has first priority), hold_cnt=0. Deassertion is sampled on posedge clk.
//   FSM: IDLE, GRANT, GAP.
//   IDLE: if req!=0 at posedge, pick first set bit scanning ptr+1, ptr+2 ... mod N
//     (wraps N-1 -> 0); next cycle gnt=onehot(winner), gnt_id=winner, ptr=winner,
//     hold_cnt=1, state=GRANT. Latency: req sampled at edge k -> gnt high after edge k.
//     req==0 -> stay IDLE, outputs 0.
//   GRANT (owner o): at each posedge, release if done[o]=1 OR req[o]=0 OR hold_cnt==MAX_HOLD.
//     On release: gnt=0, gnt_valid=0, gnt_id=0, state=GAP. On release by hold limit only
//     (done[o]=0 and req[o]=1), timeout=1 for that one cycle. Otherwise hold_cnt+=1, gnt unchanged.
//     MAX_HOLD=1 -> every grant lasts exactly one cycle.
//   GAP: one cycle, gnt=0, timeout cleared; then behaves exactly as IDLE on the next edge.
//     Net: minimum 1 zero-grant cycle between any two grants, even to the same requester.
//   Simultaneous events: done[o] and hold limit on the same edge -> release, timeout=0.
//     done/req of non-owners in GRANT are ignored (no pre-emption).
//     Multiple req in IDLE -> strictly round-robin from ptr; the timed-out owner is lowest priority next.
//   Reset mid-GRANT: gnt drops to 0 asynchronously; no timeout pulse.
//   Invariants (asserted in RTL under `ifdef ASSERT_ON): $onehot0(gnt); gnt_valid==|gnt;
//     gnt_valid -> gnt[gnt_id]; timeout -> !gnt_valid; no consecutive cycles with different non-zero gnt.
//   hold_cnt width $clog2(MAX_HOLD+1); never exceeds MAX_HOLD.
//
// TESTING
//   1. Reset: rst_n=0 with req=4'b1111 -> gnt=0, gnt_valid=0, timeout=0; release, first grant gnt=4'b0001.
//   2. Round-robin: req=4'b1111 held, done[owner] pulsed on every 2nd granted cycle -> grants
//      0001,0000,0010,0000,0100,0000,1000,0000,0001 (wrap) with a zero gap between each.
//   3. Hold limit: req=4'b0100 held, done=0 -> gnt=0100 for exactly 8 cycles, then gnt=0 with
//      timeout=1 for 1 cycle, then gnt=0100 again.
//   4. Request drop: owner 1 deasserts req[1] after 3 granted cycles -> gnt=0 next edge, timeout=0,
//      pending req[3] granted after the gap cycle.
//   5. Simultaneous: done[o]=1 on the 8th granted cycle -> release with timeout=0; done[2] while
//      owner is 0 -> ignored, gnt stays 0001.
//   6. Async reset mid-GRANT: rst_n low between edges while gnt=0010 -> gnt=0 immediately; all
//      invariant assertions pass for the whole run under random req/done for 10k cycles.

Source files
------------

// File: rtl/onehot_grant_arbiter.sv
// ---------------------------------------------------------------------------
// onehot_grant_arbiter
//
// Round-robin arbiter that produces a registered grant vector which is always
// one-hot or all-zero. A grant is held until the owner pulses done, drops its
// request, or has held the grant for MAX_HOLD cycles. Every release goes
// through a single zero-grant GAP cycle before the next grant can be issued
// (break-before-make), even when the same requester wins again.
//
// Parameters
//   N         number of requesters (>=2)
//   MAX_HOLD  maximum consecutive cycles one grant may stay high (>=1)
//
// Ports
//   clk        in   1          clock, all state updates on posedge
//   rst_n      in   1          asynchronous active-low reset
//   req        in   N          level-sensitive request per requester
//   done       in   N          owner-finished pulse, only done[owner] is used
//   gnt        out  N          registered grant, one-hot or zero
//   gnt_valid  out  1          registered, equals |gnt
//   gnt_id     out  clog2(N)   registered index of the owner, 0 when idle
//   timeout    out  1          one-cycle pulse when MAX_HOLD revokes a grant
// ---------------------------------------------------------------------------
module onehot_grant_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 timeout
);

    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   ptr_q;      // last winner; scanning starts at ptr_q+1
    logic [HW-1:0]    hold_q;     // cycles the current grant has been high
    logic [N-1:0]     gnt_q;
    logic             gnt_valid_q;
    logic [IDW-1:0]   gnt_id_q;
    logic             timeout_q;

    // -----------------------------------------------------------------------
    // Round-robin pick: first set request scanning ptr+1, ptr+2, ... mod N.
    // The last winner (ptr itself) is looked at last, so a requester that
    // just held the bus has lowest priority next time.
    // -----------------------------------------------------------------------
    logic           win_found_d;
    logic [IDW-1:0] win_id_d;
    logic [N-1:0]   win_onehot_d;

    always_comb begin
        win_found_d = 1'b0;
        win_id_d    = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N;
            if (!win_found_d && req[idx]) begin
                win_found_d = 1'b1;
                win_id_d    = IDW'(idx);
            end
        end
        win_onehot_d = N'(1) << win_id_d;
    end

    // -----------------------------------------------------------------------
    // Release decision for the current owner. Non-owner req/done are ignored,
    // so there is no pre-emption. timeout fires only when the hold limit is
    // the sole reason for the release.
    // -----------------------------------------------------------------------
    logic own_done_d;
    logic own_req_d;
    logic at_limit_d;
    logic release_d;
    logic tmo_d;

    always_comb begin
        own_done_d = done[gnt_id_q];
        own_req_d  = req[gnt_id_q];
        at_limit_d = (hold_q == HW'(MAX_HOLD));
        release_d  = own_done_d || !own_req_d || at_limit_d;
        tmo_d      = at_limit_d && !own_done_d && own_req_d;
    end

    // -----------------------------------------------------------------------
    // FSM with registered outputs. IDLE and GAP arbitrate identically; GAP
    // exists so that the cycle right after a release always shows gnt=0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(N - 1);
            hold_q      <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, GAP: begin
                    timeout_q <= 1'b0;
                    if (win_found_d) begin
                        state_q     <= GRANT;
                        ptr_q       <= win_id_d;
                        hold_q      <= HW'(1);
                        gnt_q       <= win_onehot_d;
                        gnt_valid_q <= 1'b1;
                        gnt_id_q    <= win_id_d;
                    end else begin
                        state_q     <= IDLE;
                        hold_q      <= '0;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        gnt_id_q    <= '0;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        state_q     <= GAP;
                        hold_q      <= '0;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        gnt_id_q    <= '0;
                        timeout_q   <= tmo_d;
                    end else begin
                        // hold_q < MAX_HOLD here, so the increment never overflows
                        hold_q    <= hold_q + HW'(1);
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    hold_q      <= '0;
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                    gnt_id_q    <= '0;
                    timeout_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;

`ifdef ASSERT_ON
    a_onehot0 : assert property (@(posedge clk) $onehot0(gnt));
    a_valid_eq : assert property (@(posedge clk) gnt_valid == (|gnt));
    a_id_match : assert property (@(posedge clk) gnt_valid |-> gnt[gnt_id]);
    a_tmo_idle : assert property (@(posedge clk) timeout |-> !gnt_valid);
    a_no_switch : assert property (@(posedge clk) disable iff (!rst_n)
        (gnt_valid && $past(gnt_valid)) |-> (gnt == $past(gnt)));
    a_hold_max : assert property (@(posedge clk) hold_q <= HW'(MAX_HOLD));
`endif

endmodule

// File: tb/tb_onehot_grant_arbiter.sv
module tb_onehot_grant_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: owner index (-1 = nobody), cycles held, last winner
    int m_owner;
    int m_held;
    int m_last;
    bit m_tmo;

    onehot_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = N - 1;
        m_tmo   = 0;
    endtask

    // Advance the reference by one clock edge using the current inputs.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (m_owner >= 0) begin
            if (done[m_owner] || !req[m_owner] || m_held == MAX_HOLD) begin
                m_tmo   = !done[m_owner] && req[m_owner];
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held++;
                m_tmo = 0;
            end
        end else begin
            m_tmo = 0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (req[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check("gnt", 32'(gnt), 32'(eg));
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check("timeout", 32'(timeout), 32'(m_tmo));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic settle();
        req  = '0;
        done = '0;
        step();
        step();
    endtask

    initial begin
        logic [N-1:0] rr_exp [9];
        logic [N-1:0] rr_seen [$];
        int run;
        bit seen;
        int guard;

        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001};

        // 1. reset with all requests pending
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = '0;
        model_reset();
        #1;
        check_outputs();
        step();
        step();
        check("reset_gnt", 32'(gnt), 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("first_gnt", 32'(gnt), 32'b0001);

        // 2. round-robin, done on the 2nd granted cycle of each owner
        rr_seen.push_back(gnt);
        for (int i = 0; i < 14; i++) begin
            done = (m_owner >= 0 && m_held == 2) ? (N'(1) << m_owner) : '0;
            step();
            if (gnt !== rr_seen[$]) rr_seen.push_back(gnt);
        end
        for (int i = 0; i < 9; i++) begin
            if (i < rr_seen.size()) check("rr_seq", 32'(rr_seen[i]), 32'(rr_exp[i]));
            else                    check("rr_seq_len", 32'(rr_seen.size()), 32'd9);
        end

        // 3. hold limit: single requester, never done
        settle();
        req  = 4'b0100;
        run  = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (gnt === 4'b0100) run++;
            else if (timeout === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("hold_timeout_seen", 32'(seen), 32'd1);
        check("hold_run", 32'(run), 32'd8);
        check("hold_gap_gnt", 32'(gnt), 32'd0);
        step();
        check("hold_regrant", 32'(gnt), 32'b0100);

        // 4. owner 1 drops request after 3 cycles, req[3] pending
        settle();
        req = 4'b0010;
        step();
        check("drop_owner", 32'(gnt), 32'b0010);
        req = 4'b1010;
        step();
        step();
        req = 4'b1000;
        step();
        check("drop_release", 32'(gnt), 32'd0);
        check("drop_no_tmo", 32'(timeout), 32'd0);
        step();
        check("drop_next", 32'(gnt), 32'b1000);

        // 5. non-owner done ignored; done coinciding with hold limit
        settle();
        req = 4'b0001;
        step();
        req  = 4'b0101;
        done = 4'b0100;
        step();
        check("sim_ignore", 32'(gnt), 32'b0001);
        done  = '0;
        guard = 0;
        while (m_held < MAX_HOLD && guard < 20) begin
            step();
            guard++;
        end
        check("sim_reach_limit", 32'(m_held), 32'(MAX_HOLD));
        done = 4'b0001;
        step();
        check("sim_release", 32'(gnt), 32'd0);
        check("sim_no_tmo", 32'(timeout), 32'd0);
        done = '0;
        step();
        check("sim_rr_next", 32'(gnt), 32'b0100);

        // 6. async reset between edges while owner 1 holds the grant
        settle();
        req = 4'b0010;
        step();
        check("arst_pre", 32'(gnt), 32'b0010);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_valid", 32'(gnt_valid), 32'd0);
        check("arst_tmo", 32'(timeout), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("arst_regrant", 32'(gnt), 32'b0010);

        // random phase
        for (int i = 0; i < 10000; i++) begin
            req  = N'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            if ($urandom_range(0, 1) == 0) req = req | (m_owner >= 0 ? N'(1) << m_owner : '0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
